// File: rtl/systolic_feeder.sv
// Operand buffer and skew generator in front of an N x N systolic MAC array.
// Loads A row-wise and B column-wise over valid/ready, feeds the array edges with a
// diagonal skew, holds the result until acknowledged, then clears the accumulators.
module systolic_feeder #(
  parameter int unsigned BITWIDTH = 4,
  parameter int unsigned N        = 4
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [N*BITWIDTH-1:0] i_aRow,
  input  logic [N*BITWIDTH-1:0] i_bCol,
  output logic [N*BITWIDTH-1:0] o_a,
  output logic [N*BITWIDTH-1:0] o_b,
  output logic                  o_doProcess,
  output logic                  o_resultValid,
  input  logic                  i_resultAck
);

  localparam int unsigned BeatW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FeedW = $clog2(3 * N - 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(N - 1);
  localparam logic [FeedW-1:0] LastFeed = FeedW'(3 * N - 3);

  typedef enum logic [1:0] {StLoad, StFeed, StHold, StClear} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [FeedW-1:0]   feed_q, feed_d;

  // a_mem[row][col] holds A, b_mem[row][col] holds B
  logic [BITWIDTH-1:0] a_mem [N][N];
  logic [BITWIDTH-1:0] b_mem [N][N];

  logic                  accept;
  logic                  ready_d;
  logic                  do_process_d;
  logic                  result_valid_d;
  logic [N*BITWIDTH-1:0] a_d;
  logic [N*BITWIDTH-1:0] b_d;

  assign accept = (state_q == StLoad) && i_valid && o_ready;

  // State, counters and registered outputs; reset aborts any operation in flight
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q       <= StLoad;
      beat_q        <= '0;
      feed_q        <= '0;
      o_ready       <= 1'b0;
      o_doProcess   <= 1'b0;
      o_resultValid <= 1'b0;
      o_a           <= '0;
      o_b           <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      feed_q        <= feed_d;
      o_ready       <= ready_d;
      o_doProcess   <= do_process_d;
      o_resultValid <= result_valid_d;
      o_a           <= a_d;
      o_b           <= b_d;
    end
  end

  // Operand capture: beat k carries row k of A and column k of B
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int j = 0; j < N; j++) begin
        a_mem[beat_q][j] <= i_aRow[j*BITWIDTH +: BITWIDTH];
        b_mem[j][beat_q] <= i_bCol[j*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Next-state and counter logic; counters stop by state change, never by wrapping
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    feed_d  = feed_q;
    unique case (state_q)
      StLoad: begin
        if (accept) begin
          if (beat_q == LastBeat) begin
            state_d = StFeed;
            beat_d  = '0;
            feed_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StFeed: begin
        if (feed_q == LastFeed) begin
          state_d = StHold;
          feed_d  = '0;
        end else begin
          feed_d = feed_q + 1'b1;
        end
      end
      StHold: begin
        if (i_resultAck) state_d = StClear;
      end
      StClear: state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so they line up with it
  always_comb begin
    ready_d        = (state_d == StLoad);
    do_process_d   = (state_d == StFeed) || (state_d == StHold);
    result_valid_d = (state_d == StHold);
    a_d            = '0;
    b_d            = '0;
    if (state_d == StFeed) begin
      // Lane r carries element k = t - r, so PE(r,c) meets A[r][k] and B[k][c] at t = k+r+c
      for (int r = 0; r < N; r++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(feed_d) == r + k) begin
            a_d[r*BITWIDTH +: BITWIDTH] = a_mem[r][k];
            b_d[r*BITWIDTH +: BITWIDTH] = b_mem[k][r];
          end
        end
      end
    end
  end

endmodule
